// File: rtl/mux_arbitro.sv
// mux_arbitro
//   Arbitrates one channel of a 1-of-2 FET mux between two requesters.
//   Every channel change is break-before-make: disable, settle, move the
//   select, settle, enable, settle, then grant. It also counts select changes
//   as an activity metric.
//
// Ports
//   clk           in   rising-edge clock
//   notreset      in   synchronous reset, active low
//   req[1:0]      in   req[i]=1: requester i wants channel i (level)
//   grant[1:0]    out  grant[i]=1: channel i connected and settled
//   s             out  mux select, 0 = channel 0, 1 = channel 1
//   notoe         out  mux output disable, 1 = high-Z
//   busy          out  1 whenever the FSM is not idle
//   switch_count  out  number of select changes since reset, wraps at 255
//
// state | meaning
// IDLE  | mux disabled, nothing granted
// SEL   | select driven, outputs still disabled, waiting TSEL
// EN    | outputs enabled, waiting TEN before granting
// OWN   | channel granted; cnt counts hold time up to TMAX
// DIS   | outputs disabled, waiting TDIS before select may move

module mux_arbitro #(
    parameter int TSEL = 2,
    parameter int TEN  = 2,
    parameter int TDIS = 2,
    parameter int TMAX = 16,
    parameter int CW   = 5
) (
    input  logic       clk,
    input  logic       notreset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       s,
    output logic       notoe,
    output logic       busy,
    output logic [7:0] switch_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        EN   = 3'd2,
        OWN  = 3'd3,
        DIS  = 3'd4
    } state_t;

    localparam logic [CW-1:0] TSEL_C = CW'(TSEL);
    localparam logic [CW-1:0] TEN_C  = CW'(TEN);
    localparam logic [CW-1:0] TDIS_C = CW'(TDIS);
    localparam logic [CW-1:0] TMAX_C = CW'(TMAX);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          winner;

    // Only meaningful when req != 00: a lone requester wins, a tie goes to
    // the channel that did not win last time.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last;
        end
    end

    always_ff @(posedge clk) begin
        if (!notreset) begin
            state        <= IDLE;
            s            <= 1'b0;
            notoe        <= 1'b1;
            grant        <= 2'b00;
            busy         <= 1'b0;
            switch_count <= 8'd0;
            cnt          <= '0;
            last         <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    notoe <= 1'b1;
                    grant <= 2'b00;
                    if (req != 2'b00) begin
                        state <= SEL;
                        busy  <= 1'b1;
                        cnt   <= TSEL_C;
                        s     <= winner;
                        last  <= winner;
                        if (winner != s) begin
                            switch_count <= switch_count + 8'd1;
                        end
                    end
                end

                SEL: begin
                    // notoe never fell here, so an abort can go straight idle
                    if (!req[s]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt <= ONE_C) begin
                        state <= EN;
                        notoe <= 1'b0;
                        cnt   <= TEN_C;
                    end else begin
                        cnt <= cnt - ONE_C;
                    end
                end

                EN: begin
                    if (!req[s]) begin
                        state <= DIS;
                        notoe <= 1'b1;
                        cnt   <= TDIS_C;
                    end else if (cnt <= ONE_C) begin
                        state <= OWN;
                        grant <= {s, ~s};
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - ONE_C;
                    end
                end

                OWN: begin
                    // grant falls and notoe rises on the same edge
                    if (!req[s] ||
                        ((TMAX != 0) && (cnt == TMAX_C) && req[~s])) begin
                        state <= DIS;
                        grant <= 2'b00;
                        notoe <= 1'b1;
                        cnt   <= TDIS_C;
                    end else if (cnt != TMAX_C) begin
                        cnt <= cnt + ONE_C;
                    end
                end

                DIS: begin
                    if (cnt <= ONE_C) begin
                        if (req != 2'b00) begin
                            state <= SEL;
                            cnt   <= TSEL_C;
                            s     <= winner;
                            last  <= winner;
                            if (winner != s) begin
                                switch_count <= switch_count + 8'd1;
                            end
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - ONE_C;
                    end
                end

                default: begin
                    state <= IDLE;
                    notoe <= 1'b1;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
